// File: rtl/iob_vexriscv_bus_bridge.sv
// iob_vexriscv_bus_bridge: VexRiscv cmd/rsp stream to IOb bridge (cmd_* request in, rsp_* read data out, iob_* IOb master, err_unexp/busy status); `define IOB_VEXRISCV_BRIDGE_REMAP_EN enables the boot-dependent address MSB remap
module iob_vexriscv_bus_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MAX_OUTST = 2,
  parameter int P_BIT = 30,
  parameter int E_BIT = 31
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                boot,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_wr,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_mask,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_error,
  output logic                iob_valid,
  output logic [ADDR_W-1:0]   iob_addr,
  output logic [DATA_W-1:0]   iob_wdata,
  output logic [DATA_W/8-1:0] iob_wstrb,
  input  logic                iob_ready,
  input  logic                iob_rvalid,
  input  logic [DATA_W-1:0]   iob_rdata,
  output logic                err_unexp,
  output logic                busy
);
  localparam int CW = $clog2(MAX_OUTST + 1);
  logic valid_q, valid_d, err_q, err_d, hs, load, rd_hs, dec;
  logic [ADDR_W-1:0] addr_q, addr_d, maddr;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic [CW-1:0] cnt_q, cnt_d;
`ifdef IOB_VEXRISCV_BRIDGE_REMAP_EN
  assign maddr = {(~boot & ~cmd_addr[P_BIT]) | cmd_addr[E_BIT], cmd_addr[ADDR_W-2:0]};
`else
  logic unused_ok;
  assign unused_ok = ^{boot, P_BIT, E_BIT};
  assign maddr = cmd_addr;
`endif
  always_comb begin
    cmd_ready = (!valid_q | iob_ready) & (cnt_q < CW'(MAX_OUTST));
    hs = cmd_valid & cmd_ready;
    load = hs & (!cmd_wr | (|cmd_mask));
    rd_hs = hs & !cmd_wr;
    dec = iob_rvalid & (cnt_q != '0);
    valid_d = load | (valid_q & !iob_ready);
    addr_d = load ? maddr : addr_q;
    wdata_d = load ? cmd_wdata : wdata_q;
    wstrb_d = load ? (cmd_wr ? cmd_mask : '0) : wstrb_q;
    cnt_d = cnt_q + CW'(rd_hs) - CW'(dec);
    err_d = err_q | (iob_rvalid & (cnt_q == '0));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign iob_valid = valid_q;
  assign iob_addr = addr_q;
  assign iob_wdata = wdata_q;
  assign iob_wstrb = wstrb_q;
  assign rsp_valid = iob_rvalid;
  assign rsp_rdata = iob_rdata;
  assign rsp_error = 1'b0;
  assign err_unexp = err_q;
  assign busy = valid_q | (cnt_q != '0);
endmodule

// File: tb/tb_iob_vexriscv_bus_bridge.sv
// tb_iob_vexriscv_bus_bridge: scoreboard bench for the VexRiscv to IOb bridge
module tb_iob_vexriscv_bus_bridge;
  localparam int MAX = 2;
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0] s;
  } req_t;
  logic clk = 0, rst = 1, boot = 1, cmd_valid = 0, cmd_wr = 0, iob_ready = 0, iob_rvalid = 0;
  logic [31:0] cmd_addr = 0, cmd_wdata = 0, iob_rdata = 0;
  logic [3:0] cmd_mask = 0;
  logic cmd_ready, rsp_valid, rsp_error, iob_valid, err_unexp, busy;
  logic [31:0] rsp_rdata, iob_addr, iob_wdata;
  logic [3:0] iob_wstrb;
  int checks = 0, errors = 0, outst = 0;
  logic exp_err = 0, pv = 0;
  logic [31:0] pa, pd;
  logic [3:0] ps;
  req_t exp_req[$];
  logic [31:0] exp_rsp[$];
  logic [31:0] pend[$];
  logic [31:0] mem[logic [31:0]];

  iob_vexriscv_bus_bridge dut (
    .clk(clk), .rst(rst), .boot(boot), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .iob_valid(iob_valid), .iob_addr(iob_addr), .iob_wdata(iob_wdata), .iob_wstrb(iob_wstrb),
    .iob_ready(iob_ready), .iob_rvalid(iob_rvalid), .iob_rdata(iob_rdata),
    .err_unexp(err_unexp), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] map(input logic [31:0] a, input logic b);
`ifdef IOB_VEXRISCV_BRIDGE_REMAP_EN
    return {(~b & ~a[30]) | a[31], a[30:0]};
`else
    return a;
`endif
  endfunction

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : ((a * 32'h9E3779B1) ^ 32'h5A5A5A5A);
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic step();
    req_t r;
    #1;
    if (!rst && cmd_valid && cmd_ready) begin
      r.a = map(cmd_addr, boot);
      r.d = cmd_wdata;
      r.s = cmd_wr ? cmd_mask : 4'h0;
      if (!cmd_wr || cmd_mask != 0) exp_req.push_back(r);
      if (!cmd_wr) exp_rsp.push_back(rd(r.a));
    end
    if (!rst && iob_valid && iob_ready && iob_wstrb == 0) pend.push_back(iob_addr);
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    cmd_valid = 1;
    cmd_wr = w;
    cmd_addr = a;
    cmd_wdata = d;
    cmd_mask = m;
  endtask

  task automatic give();
    iob_rvalid = pend.size() != 0;
    iob_rdata = pend.size() != 0 ? rd(pend.pop_front()) : 32'h0;
  endtask

  task automatic resp();
    give();
    step();
    iob_rvalid = 0;
  endtask

  task automatic remap_chk(input logic b, input logic [31:0] a, input logic [31:0] e);
    boot = b;
    iob_ready = 1;
    cmd(0, a, 0, 0);
    step();
    cmd_valid = 0;
    chk("remap_addr", iob_addr, e);
    step();
    resp();
  endtask

  always @(negedge clk) begin
    req_t r;
    if (rst) begin
      outst = 0;
      exp_err = 0;
      pv = 0;
      exp_req.delete();
      exp_rsp.delete();
    end else begin
      chk("rsp_error", rsp_error, 0);
      chk("rsp_valid", rsp_valid, iob_rvalid);
      chk("err_unexp", err_unexp, exp_err);
      chk("busy", busy, iob_valid | (outst != 0));
      chk("cmd_ready", cmd_ready, (outst < MAX) & (!iob_valid | iob_ready));
      if (pv) begin
        chk("hold_valid", iob_valid, 1);
        chk("hold_addr", iob_addr, pa);
        chk("hold_wdata", iob_wdata, pd);
        chk("hold_wstrb", iob_wstrb, ps);
      end
      if (iob_valid && iob_ready) begin
        if (exp_req.size() == 0) chk("iob_req_queue", exp_req.size(), 1);
        else begin
          r = exp_req.pop_front();
          chk("iob_addr", iob_addr, r.a);
          chk("iob_wstrb", iob_wstrb, r.s);
          if (r.s != 0) chk("iob_wdata", iob_wdata, r.d);
        end
      end
      if (rsp_valid && outst > 0) begin
        if (exp_rsp.size() == 0) chk("rsp_queue", exp_rsp.size(), 1);
        else chk("rsp_rdata", rsp_rdata, exp_rsp.pop_front());
      end
      if (iob_rvalid) begin
        if (outst == 0) exp_err = 1;
        else outst--;
      end
      if (cmd_valid && cmd_ready && !cmd_wr) outst++;
      pv = iob_valid & !iob_ready;
      pa = iob_addr;
      pd = iob_wdata;
      ps = iob_wstrb;
    end
  end

  initial begin
    mem[32'h100] = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_iob_valid", iob_valid, 0);
    chk("rst_iob_addr", iob_addr, 0);
    chk("rst_iob_wdata", iob_wdata, 0);
    chk("rst_iob_wstrb", iob_wstrb, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_unexp, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    rst = 0;
    step();
    iob_ready = 1;
    cmd(0, 32'h100, 0, 0);
    step();
    cmd_valid = 0;
    chk("t1_iob_valid", iob_valid, 1);
    chk("t1_iob_addr", iob_addr, 32'h100);
    chk("t1_iob_wstrb", iob_wstrb, 0);
    step();
    give();
    #1;
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    step();
    iob_rvalid = 0;
    chk("t1_busy", busy, 0);
    iob_ready = 0;
    cmd(1, 32'h20, 32'h12345678, 4'hF);
    step();
    cmd_valid = 0;
    repeat (3) begin
      chk("t2_valid", iob_valid, 1);
      chk("t2_addr", iob_addr, 32'h20);
      chk("t2_wdata", iob_wdata, 32'h12345678);
      chk("t2_wstrb", iob_wstrb, 4'hF);
      chk("t2_cmd_ready", cmd_ready, 0);
      step();
    end
    iob_ready = 1;
    step();
    chk("t2_drained", iob_valid, 0);
    chk("t2_busy", busy, 0);
    cmd(0, 32'h200, 0, 0);
    step();
    cmd(0, 32'h204, 0, 0);
    step();
    cmd(0, 32'h208, 0, 0);
    #1;
    chk("t3_third_stall", cmd_ready, 0);
    step();
    give();
    #1;
    chk("t3_stall_rvalid", cmd_ready, 0);
    step();
    iob_rvalid = 0;
    #1;
    chk("t3_ready_after", cmd_ready, 1);
    step();
    cmd_valid = 0;
    resp();
    resp();
    chk("t3_busy", busy, 0);
    cmd(0, 32'h300, 0, 0);
    step();
    cmd_valid = 0;
    step();
    cmd(0, 32'h304, 0, 0);
    give();
    step();
    cmd_valid = 0;
    iob_rvalid = 0;
    step();
    chk("t4_idle_stage", iob_valid, 0);
    chk("t4_cnt_one", busy, 1);
    resp();
    chk("t4_cnt_zero", busy, 0);
    cmd(1, 32'h40, 32'hCAFEF00D, 4'h0);
    #1;
    chk("t4_mask0_ready", cmd_ready, 1);
    step();
    cmd_valid = 0;
    repeat (2) begin
      chk("t4_mask0_novalid", iob_valid, 0);
      step();
    end
    chk("t5_err_before", err_unexp, 0);
    iob_rvalid = 1;
    iob_rdata = 32'h55;
    #1;
    chk("t5_rsp_fwd", rsp_valid, 1);
    step();
    iob_rvalid = 0;
    chk("t5_err_set", err_unexp, 1);
    chk("t5_busy", busy, 0);
    step();
    chk("t5_err_sticky", err_unexp, 1);
    rst = 1;
    step();
    rst = 0;
    chk("t5_err_clr", err_unexp, 0);
    chk("t5_busy_clr", busy, 0);
    step();
`ifdef IOB_VEXRISCV_BRIDGE_REMAP_EN
    remap_chk(0, 32'h00001000, 32'h80001000);
    remap_chk(1, 32'h00001000, 32'h00001000);
    remap_chk(0, 32'h40000000, 32'h40000000);
`endif
    pend.delete();
    for (int i = 0; i < 3000; i++) begin
      boot = 1'($urandom);
      iob_ready = $urandom_range(0, 3) != 0;
      if (pend.size() != 0 && $urandom_range(0, 1) == 1) give();
      else iob_rvalid = 0;
      cmd_valid = 1'($urandom);
      cmd_wr = 1'($urandom);
      cmd_addr = $urandom;
      cmd_wdata = $urandom;
      cmd_mask = 4'($urandom_range(0, 15));
      step();
    end
    cmd_valid = 0;
    iob_ready = 1;
    for (int i = 0; i < 200 && (pend.size() != 0 || busy); i++) begin
      give();
      step();
    end
    iob_rvalid = 0;
    step();
    chk("end_req_queue", exp_req.size(), 0);
    chk("end_rsp_queue", exp_rsp.size(), 0);
    chk("end_busy", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/iob_vexriscv_bus_bridge.md
Name: iob_vexriscv_bus_bridge

Overview:
- Parametrised bridge from a VexRiscv-style cmd/rsp stream master (iBus or dBus) to the IOb native bus.
- Instantiated once per CPU bus in the core wrapper. Replaces the ad-hoc hold registers with a registered request stage and a read-credit counter.
- Supports multiple outstanding reads, posted writes and an optional boot-dependent address remap.

Parameters:
- ADDR_W, 32, address width of both sides.
- DATA_W, 32, data width; strobe width is DATA_W/8.
- MAX_OUTST, 2, maximum reads accepted on the cmd side but not yet answered (≥1).
- P_BIT, 30, peripheral-select address bit (remap only).
- E_BIT, 31, external-memory-select address bit (remap only).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- boot  in  1  1 = boot ROM phase (remap only)
- cmd_valid  in  1  request valid
- cmd_ready  out  1  request accepted this cycle
- cmd_wr  in  1  1 = write
- cmd_addr  in  ADDR_W  byte address
- cmd_wdata  in  DATA_W  write data
- cmd_mask  in  DATA_W/8  byte-enable for writes
- rsp_valid  out  1  read data valid
- rsp_rdata  out  DATA_W  read data
- rsp_error  out  1  constant 0
- iob_valid  out  1  IOb request valid
- iob_addr  out  ADDR_W  IOb address
- iob_wdata  out  DATA_W  IOb write data
- iob_wstrb  out  DATA_W/8  IOb strobe; 0 = read
- iob_ready  in  1  IOb request accepted
- iob_rvalid  in  1  IOb read data valid
- iob_rdata  in  DATA_W  IOb read data
- err_unexp  out  1  sticky: iob_rvalid seen with no read in flight
- busy  out  1  valid_q | (cnt != 0)

Behaviour:
- Reset values: valid_q, cnt and err_unexp are 0. iob_addr, iob_wdata and iob_wstrb are 0. Hence iob_valid=0, busy=0 and rsp_valid follows iob_rvalid (0 when idle).
- Request stage is a single register set: valid_q, addr_q, wdata_q, wstrb_q. iob_valid = valid_q; iob_* come directly from the registers.
- cmd_ready = (!valid_q | iob_ready) & (cnt < MAX_OUTST). This is combinational on iob_ready; the stall applies to writes as well as reads.
- On a cmd handshake, the registers load on the next edge:
  - wstrb_q = cmd_wr ? cmd_mask : 0.
  - Latency is 1 cycle from handshake to iob_valid.
- Write with cmd_mask == 0: accepted and dropped. Registers are not loaded, valid_q ← 0 if it is being drained, and cnt is unchanged.
- With valid_q=1 and iob_ready=0: all iob_* outputs hold stable, with no change until iob_ready=1.
- Drained without a new cmd: valid_q ← 0. When iob_ready=1 and a cmd handshake occur in the same cycle, the registers reload back-to-back (full throughput).
- cnt, width $clog2(MAX_OUTST+1):
  - +1 on a read cmd handshake.
  - −1 on iob_rvalid.
  - Both in the same cycle: unchanged.
  - Never exceeds MAX_OUTST.
- rsp_valid = iob_rvalid and rsp_rdata = iob_rdata, combinationally. Responses return in order. Writes are posted and produce no rsp.
- iob_rvalid with cnt==0: cnt stays 0 (no underflow), err_unexp ← 1 until reset, and rsp_valid is still forwarded.
- Reset mid-transaction aborts immediately. In-flight reads are forgotten; any later rvalid for them sets err_unexp.

Optional Feature:
- Macro: IOB_VEXRISCV_BRIDGE_REMAP_EN.
- Defined: when loading addr_q, bit ADDR_W-1 = (~boot & ~cmd_addr[P_BIT]) | cmd_addr[E_BIT]; the other bits are copied.
- Undefined: addr_q = cmd_addr unchanged and the boot port is ignored.

Test Plan:
- Reset, then a read cmd at addr 0x100 with iob_ready=1: iob_valid=1 and iob_addr=0x100 one cycle later, iob_wstrb=0. Respond with iob_rvalid and rdata 0xDEADBEEF: rsp_valid=1 with that data, cnt returns to 0, busy=0.
- Write addr 0x20, data 0x12345678, mask 0xF, with iob_ready=0 for 3 cycles: iob_* stable 3 cycles, cmd_ready=0 meanwhile. Then iob_ready=1: no rsp, cnt stays 0.
- MAX_OUTST=2, three back-to-back reads, iob_ready=1, no rvalid: third cmd_ready=0 until the first rvalid. Three rvalids give three rsp in order; cnt goes 2→1→0.
- Read cmd handshake in the same cycle as iob_rvalid with cnt=1: cnt stays 1. Write with mask 0: cmd_ready=1 and iob_valid never rises.
- iob_rvalid with cnt=0: err_unexp=1 and sticky; cnt stays 0. rst pulse clears it and busy.
- REMAP_EN, boot=0, read addr 0x00001000: iob_addr=0x80001000. boot=1: 0x00001000. boot=0 with P_BIT set (0x40000000): MSB stays 0.
